// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: round-robin arbiter sharing one DDR read port between REQ_NUM requesters,
// with a watchdog that forces release of a transfer that never completes.
module ddr_rd_arbiter #(
   parameter int REQ_NUM       = 3,
   parameter int ADDR_WIDTH    = 30,
   parameter int DATA_NUM_BITS = 16,
   parameter int TIMEOUT_CYC   = 65535,
   parameter int GID_W         = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             init_calib_complete_i,
   input  logic [REQ_NUM-1:0]               req_i,
   output logic [REQ_NUM-1:0]               ack_o,
   input  logic [REQ_NUM-1:0]               req_rd_en_i,
   input  logic [REQ_NUM*DATA_NUM_BITS-1:0] req_burst_num_i,
   input  logic [REQ_NUM*ADDR_WIDTH-1:0]    req_start_addr_i,
   output logic [REQ_NUM-1:0]               done_o,
   output logic                             ddr_rd_en_o,
   output logic [DATA_NUM_BITS-1:0]         ddr_burst_num_o,
   output logic [ADDR_WIDTH-1:0]            ddr_start_addr_o,
   input  logic                             ddr_rd_done_i,
   output logic [GID_W-1:0]                 grant_id_o,
   output logic                             busy_o,
   output logic                             err_o
);
   typedef enum logic [1:0] {IDLE, ACK, XFER, RELEASE} state_t;
   state_t           state_q, state_d;
   logic [GID_W-1:0] grant_q, grant_d, last_q, last_d, winner;
   logic [19:0]      wdog_q, wdog_d;
   logic             err_q, err_d, found, xfer;
   // Descending scan so the smallest rotation offset from last_q wins.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = REQ_NUM; i >= 1; i--) begin
         if (req_i[(int'(last_q) + i) % REQ_NUM]) begin
            winner = GID_W'((int'(last_q) + i) % REQ_NUM);
            found  = 1'b1;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wdog_d  = wdog_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (init_calib_complete_i && found) begin
            grant_d = winner;
            state_d = ACK;
         end
         ACK: begin
            wdog_d  = '0;
            state_d = XFER;
         end
         XFER: begin
            wdog_d = wdog_q + 20'd1;
            if (ddr_rd_done_i) begin
               last_d  = grant_q;
               state_d = RELEASE;
            end else if (wdog_q == 20'(TIMEOUT_CYC - 1)) begin
               err_d   = 1'b1;
               last_d  = grant_q;
               state_d = RELEASE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GID_W'(REQ_NUM - 1);
         wdog_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wdog_q  <= wdog_d;
         err_q   <= err_d;
      end
   end
   assign xfer             = state_q == XFER;
   assign ack_o            = state_q == ACK ? REQ_NUM'(1) << grant_q : '0;
   assign done_o           = xfer && ddr_rd_done_i ? REQ_NUM'(1) << grant_q : '0;
   assign ddr_rd_en_o      = xfer & req_rd_en_i[grant_q];
   assign ddr_burst_num_o  = xfer ? req_burst_num_i[int'(grant_q)*DATA_NUM_BITS +: DATA_NUM_BITS] : '0;
   assign ddr_start_addr_o = xfer ? req_start_addr_i[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign grant_id_o       = grant_q;
   assign busy_o           = state_q != IDLE;
   assign err_o            = err_q;
endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: directed scenario tests for ddr_rd_arbiter (3 requesters, 64-cycle watchdog).
module tb_ddr_rd_arbiter;
   logic        clk = 1'b0, rst = 1'b1, calib = 1'b0;
   logic [2:0]  req = '0, ack, rd_en = '0, done;
   logic [47:0] burst = '0;
   logic [89:0] addr = '0;
   logic        ddr_en, ddr_done = 1'b0, busy, err;
   logic [15:0] ddr_burst;
   logic [29:0] ddr_addr;
   logic [1:0]  gid;
   int          errors = 0, checks = 0;

   ddr_rd_arbiter #(.REQ_NUM(3), .ADDR_WIDTH(30), .DATA_NUM_BITS(16), .TIMEOUT_CYC(64), .GID_W(2)) dut (
      .clk_i(clk), .rst_i(rst), .init_calib_complete_i(calib), .req_i(req), .ack_o(ack),
      .req_rd_en_i(rd_en), .req_burst_num_i(burst), .req_start_addr_i(addr), .done_o(done),
      .ddr_rd_en_o(ddr_en), .ddr_burst_num_o(ddr_burst), .ddr_start_addr_o(ddr_addr),
      .ddr_rd_done_i(ddr_done), .grant_id_o(gid), .busy_o(busy), .err_o(err));

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; rd_en = '0; ddr_done = 1'b0; calib = 1'b1; burst = '0; addr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ack(output logic [2:0] v);
      v = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ack != 0) begin
            v = ack;
            break;
         end
      end
   endtask

   // Serves the next grant: drives the winner's command, pulses done after dly XFER cycles,
   // and returns the ack vector plus burst/done seen on the done cycle. Ends in RELEASE.
   task automatic run_xfer(input int dly, output logic [2:0] v, output logic [15:0] b, output logic [2:0] dn);
      int k;
      b = '0; dn = '0; k = 0;
      wait_ack(v);
      if (v == 0) return;
      for (int i = 0; i < 3; i++) if (v[i]) k = i;
      @(negedge clk);
      rd_en[k] = 1'b1;
      burst[k*16 +: 16] = 16'(100 + k);
      addr[k*30 +: 30] = 30'(k) << 20;
      repeat (dly - 1) @(negedge clk);
      ddr_done = 1'b1;
      #1 b = ddr_burst; dn = done;
      @(negedge clk);
      ddr_done = 1'b0; rd_en = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; calib = 1'b1; req = 3'b111; rd_en = 3'b111; ddr_done = 1'b1;
      #1 checks++;
      if ({ack, done, ddr_en, ddr_burst, ddr_addr, gid, busy, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ack=%b done=%b en=%b burst=%h addr=%h gid=%0d busy=%b err=%b, required all 0",
                  ack, done, ddr_en, ddr_burst, ddr_addr, gid, busy, err);
      end
      ddr_done = 1'b0; rd_en = '0; req = '0;
   endtask

   task automatic test_basic();
      do_reset();
      req = 3'b010;
      @(negedge clk);
      checks++; if (ack !== 3'b010 || gid !== 2'd1 || busy !== 1'b1) begin
         errors++; $display("FAIL basic_ack: ack=%b gid=%0d busy=%b, required 010/1/1", ack, gid, busy);
      end
      req = '0;
      @(negedge clk);
      burst[16 +: 16] = 16'd17; addr[30 +: 30] = 30'h0800_0000;
      #1 checks++; if (ack !== 3'b000 || ddr_en !== 1'b0) begin
         errors++; $display("FAIL basic_ack_width: ack=%b en=%b, required 000/0", ack, ddr_en);
      end
      rd_en[1] = 1'b1;
      #1 checks++; if (ddr_en !== 1'b1 || ddr_burst !== 16'd17 || ddr_addr !== 30'h0800_0000) begin
         errors++; $display("FAIL basic_mux: en=%b burst=%0d addr=%h, required 1/17/08000000", ddr_en, ddr_burst, ddr_addr);
      end
      repeat (19) @(negedge clk);
      checks++; if (done !== 3'b000) begin
         errors++; $display("FAIL basic_no_early_done: done=%b, required 000", done);
      end
      ddr_done = 1'b1;
      #1 checks++; if (done !== 3'b010) begin
         errors++; $display("FAIL basic_done: done=%b, required 010", done);
      end
      @(negedge clk);
      ddr_done = 1'b0;
      checks++; if (ddr_en !== 1'b0 || ddr_burst !== 16'd0 || busy !== 1'b1) begin
         errors++; $display("FAIL basic_release: en=%b burst=%0d busy=%b, required 0/0/1", ddr_en, ddr_burst, busy);
      end
      rd_en = '0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || gid !== 2'd1) begin
         errors++; $display("FAIL basic_idle: busy=%b gid=%0d, required 0/1", busy, gid);
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0] v, dn;
      logic [15:0] b;
      int exp_k[5] = '{0, 1, 2, 0, 1};
      do_reset();
      req = 3'b111;
      for (int n = 0; n < 5; n++) begin
         run_xfer(4, v, b, dn);
         checks++; if (v !== 3'(1 << exp_k[n]) || b !== 16'(100 + exp_k[n]) || dn !== v) begin
            errors++; $display("FAIL rr_order[%0d]: ack=%b burst=%0d done=%b, required ack=%b burst=%0d", n, v, b, dn,
                               3'(1 << exp_k[n]), 100 + exp_k[n]);
         end
      end
      req = '0;
   endtask

   task automatic test_fairness();
      logic [2:0] v, dn;
      logic [15:0] b;
      logic [2:0] reqs[5] = '{3'b101, 3'b101, 3'b101, 3'b001, 3'b101};
      logic [2:0] exps[5] = '{3'b001, 3'b100, 3'b001, 3'b001, 3'b100};
      do_reset();
      for (int n = 0; n < 5; n++) begin
         req = reqs[n];
         run_xfer(3, v, b, dn);
         checks++; if (v !== exps[n]) begin
            errors++; $display("FAIL fairness[%0d]: ack=%b, required %b", n, v, exps[n]);
         end
      end
      req = '0;
   endtask

   task automatic test_calib();
      int seen = 0;
      do_reset();
      calib = 1'b0; req = 3'b001;
      repeat (50) begin
         @(negedge clk);
         if (ack != 0 || busy) seen++;
      end
      checks++; if (seen !== 0) begin
         errors++; $display("FAIL calib_gate: %0d cycles with ack/busy, required 0", seen);
      end
      calib = 1'b1;
      @(negedge clk);
      checks++; if (ack !== 3'b001) begin
         errors++; $display("FAIL calib_latency: ack=%b, required 001", ack);
      end
      req = '0;
      repeat (3) @(negedge clk);
      ddr_done = 1'b1;
      @(negedge clk);
      ddr_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_watchdog();
      logic [2:0] v, dn;
      logic [15:0] b;
      do_reset();
      req = 3'b010;
      wait_ack(v);
      req = 3'b100; rd_en[1] = 1'b1;
      repeat (64) @(negedge clk);
      checks++; if (err !== 1'b0 || busy !== 1'b1 || ddr_en !== 1'b1) begin
         errors++; $display("FAIL wdog_last_xfer: err=%b busy=%b en=%b, required 0/1/1", err, busy, ddr_en);
      end
      @(negedge clk);
      checks++; if (err !== 1'b1 || ddr_en !== 1'b0 || done !== 3'b000) begin
         errors++; $display("FAIL wdog_timeout: err=%b en=%b done=%b, required 1/0/000", err, ddr_en, done);
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || gid !== 2'd1) begin
         errors++; $display("FAIL wdog_idle: busy=%b gid=%0d, required 0/1", busy, gid);
      end
      rd_en = '0;
      run_xfer(5, v, b, dn);
      checks++; if (v !== 3'b100 || dn !== 3'b100 || err !== 1'b1) begin
         errors++; $display("FAIL wdog_next_grant: ack=%b done=%b err=%b, required 100/100/1", v, dn, err);
      end
      req = '0;
   endtask

   task automatic test_done_at_timeout();
      logic [2:0] v;
      do_reset();
      req = 3'b010;
      wait_ack(v);
      req = '0;
      repeat (64) @(negedge clk);
      ddr_done = 1'b1;
      #1 checks++; if (done !== 3'b010) begin
         errors++; $display("FAIL done_at_timeout: done=%b, required 010", done);
      end
      @(negedge clk);
      ddr_done = 1'b0;
      checks++; if (err !== 1'b0) begin
         errors++; $display("FAIL done_at_timeout_err: err=%b, required 0", err);
      end
   endtask

   task automatic test_reset_mid_xfer();
      logic [2:0] v, dn;
      logic [15:0] b;
      do_reset();
      req = 3'b010;
      wait_ack(v);
      req = '0;
      @(negedge clk);
      rd_en[1] = 1'b1; burst[16 +: 16] = 16'hbeef;
      repeat (3) @(negedge clk);
      ddr_done = 1'b1; rst = 1'b1;
      #1 checks++; if ({ack, done, ddr_en, ddr_burst, gid, busy, err} !== '0) begin
         errors++; $display("FAIL reset_mid_xfer: ack=%b done=%b en=%b burst=%h gid=%0d busy=%b err=%b, required all 0",
                            ack, done, ddr_en, ddr_burst, gid, busy, err);
      end
      @(negedge clk);
      rst = 1'b0; ddr_done = 1'b0; rd_en = '0; req = 3'b101;
      run_xfer(2, v, b, dn);
      checks++; if (v !== 3'b001) begin
         errors++; $display("FAIL reset_first_grant: ack=%b, required 001", v);
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_simultaneous();
      test_fairness();
      test_calib();
      test_watchdog();
      test_done_at_timeout();
      test_reset_mid_xfer();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1);
   end
endmodule
